// File: rtl/saed32_port_ctrl_128x8.sv
// rtl/saed32_port_ctrl_128x8.sv - request/response front-end for one SAED32 128x8 SRAM port (option macro: CTRL_WRITE_ACK_EN)
module saed32_port_ctrl_128x8 #(
  parameter int AW        = 7,
  parameter int DW        = 8,
  parameter int RSP_DEPTH = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  output logic          mem_ce,
  input  logic [DW-1:0] mem_q
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

`ifdef CTRL_WRITE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          inflight;
  logic          is_wr;
  logic [DW-1:0] fifo_mem [RSP_DEPTH];

  logic [CW:0]   credits_used;
  logic          fire;
  logic          produce;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits count both stored responses and the one still coming out of the SRAM,
  // so req_ready depends on registered state only.
  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req_ready    = RST_N & (credits_used < (CW+1)'(RSP_DEPTH));
  assign fire         = req_valid & req_ready;
  assign produce      = fire & (~req_we | ACK_EN);

  assign mem_ce = fire;
  assign mem_we = fire & req_we;
  assign mem_a  = req_addr;
  assign mem_d  = req_wdata;

  assign push      = inflight;
  assign pop       = rsp_valid & rsp_ready;
  assign push_data = is_wr ? '0 : mem_q;
  assign rsp_valid = (count != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  // Control state: in-flight tracking, circular pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      is_wr    <= 1'b0;
    end else begin
      inflight <= produce;
      is_wr    <= produce & req_we;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Response storage; contents need no reset since pointers/count gate visibility.
  always_ff @(posedge CLK) begin
    if (RST_N && push) fifo_mem[wr_ptr] <= push_data;
  end

  // The credit scheme must never let a capture land in a full FIFO.
  push_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && (count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_saed32_port_ctrl_128x8.sv
// tb/tb_saed32_port_ctrl_128x8.sv - scoreboard testbench for saed32_port_ctrl_128x8
module tb_saed32_port_ctrl_128x8;

`ifdef CTRL_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [6:0] mem_a;
  logic [7:0] mem_d;
  logic       mem_we;
  logic       mem_ce;
  logic [7:0] mem_q;

  logic [7:0] sram [128];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;

  saed32_port_ctrl_128x8 #(.AW(7), .DW(8), .RSP_DEPTH(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_ce(mem_ce), .mem_q(mem_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM port model: preloaded with addr^0x3C, q registered one cycle after access.
  initial for (int i = 0; i < 128; i++) sram[i] = 8'(i) ^ 8'h3C;
  always @(posedge CLK) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_a] <= mem_d;
      else        mem_q <= sram[mem_a];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N && rsp_valid && rsp_ready) begin
      pop_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata=%0h, required no response", rsp_rdata);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (rsp_rdata !== e) begin
          n_fail++;
          $display("FAIL rsp_data: got %0h, required %0h", rsp_rdata, e);
        end
      end
    end
  end

  int stall_cycles = 0;

  // Drive one request until it fires; the expected response is queued at fire time.
  task automatic send(input logic we, input logic [6:0] a, input logic [7:0] d,
                      input bit has_rsp, input logic [7:0] exp);
    bit ok = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge CLK);
      if (req_ready) ok = 1;
      else stall_cycles++;
    end
    if (!ok) begin
      check("req_timeout", 0, 1);
    end else begin
      if (has_rsp) exp_q.push_back(exp);
      check("mem_ce_on_fire", int'(mem_ce), 1);
      check("mem_we_on_fire", int'(mem_we), int'(we));
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int p0;
    int sent;
    RST_N = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset: outputs held quiet while RST_N is low even with a pending request.
    repeat (3) begin
      @(negedge CLK);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_mem_ce", int'(mem_ce), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    check("post_rst_req_ready", int'(req_ready), 1);
    @(posedge CLK); #1;

    // Write 0xA5 to 0x7F then read it back-to-back.
    send(1'b1, 7'h7F, 8'hA5, ACK, 8'h00);
    send(1'b0, 7'h7F, 8'h00, 1'b1, 8'hA5);
    @(negedge CLK);
    check("wr_rd_valid_n1", int'(rsp_valid), int'(ACK));
    @(negedge CLK);
    check("wr_rd_valid_n2", int'(rsp_valid), 1);
    check("wr_rd_rdata_n2", int'(rsp_rdata), 8'hA5);
    repeat (3) @(posedge CLK); #1;

    // Streaming: 16 reads, no stall, 16 responses on consecutive cycles.
    p0 = pop_cnt; stall_cycles = 0;
    for (int i = 0; i < 16; i++) send(1'b0, 7'(i), 8'h00, 1'b1, 8'(i) ^ 8'h3C);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("stream_no_stall", stall_cycles, 0);
    check("stream_rsp_count", pop_cnt - p0, 16);
    check("stream_drained", int'(rsp_valid), 0);

    // Backpressure: consumer stalled, only 3 of 5 reads accepted.
    rsp_ready = 1'b0; sent = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd20;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (req_ready) begin
        exp_q.push_back(8'(20 + sent) ^ 8'h3C);
        sent++;
      end
      @(posedge CLK); #1;
      req_addr = 7'(20 + sent);
    end
    check("bp_accepted", sent, 3);
    check("bp_req_ready_low", int'(req_ready), 0);
    p0 = pop_cnt;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && sent < 5; c++) begin
      @(negedge CLK);
      if (req_ready) begin
        exp_q.push_back(8'(20 + sent) ^ 8'h3C);
        sent++;
      end
      @(posedge CLK); #1;
      req_addr = 7'(20 + sent);
    end
    req_valid = 1'b0;
    check("bp_all_sent", sent, 5);
    repeat (6) @(posedge CLK); #1;
    check("bp_rsp_count", pop_cnt - p0, 5);

    // Reset mid-stream: 2 responses stored plus 1 in flight are discarded.
    rsp_ready = 1'b0;
    send(1'b0, 7'd40, 8'h00, 1'b1, 8'd40 ^ 8'h3C);
    send(1'b0, 7'd41, 8'h00, 1'b1, 8'd41 ^ 8'h3C);
    send(1'b0, 7'd42, 8'h00, 1'b1, 8'd42 ^ 8'h3C);
    check("mid_fifo_occupied", int'(rsp_valid), 1);
    RST_N = 1'b0;
    exp_q.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("mid_rst_rsp_valid", int'(rsp_valid), 0);
    rsp_ready = 1'b1;
    p0 = pop_cnt;
    repeat (5) @(negedge CLK);
    check("mid_rst_no_stale", pop_cnt - p0, 0);
    @(posedge CLK); #1;

    // Write then read: ack adds one zero response ahead of the read data.
    p0 = pop_cnt;
    send(1'b1, 7'd3, 8'h11, ACK, 8'h00);
    send(1'b0, 7'd3, 8'h00, 1'b1, 8'h11);
    repeat (5) @(posedge CLK); #1;
    check("ack_rsp_count", pop_cnt - p0, ACK ? 2 : 1);

    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
